// File: rtl/sys_arr_feeder.sv
// Operand feeder for an N x N systolic MAC array: buffers A and B, then streams
// skewed, zero-padded wavefronts onto the array's left and top edges.
module sys_arr_feeder #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          CLK,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [IW-1:0] wr_row,
    input  logic [IW-1:0] wr_col,
    input  logic [7:0]    wr_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          pe_clr,
    output logic          pe_en,
    output logic [N*8-1:0] a_edge,
    output logic [N*8-1:0] b_edge
);

    localparam int STEPS = 3*N - 2;
    localparam int TW    = $clog2(STEPS);
    localparam logic [TW-1:0] T_LAST = TW'(STEPS - 1);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_STREAM, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   t_q, t_d;
    logic [7:0]      a_q [N][N];
    logic [7:0]      b_q [N][N];
    logic            wr_ok;
    logic [N-1:0][7:0] a_nxt, b_nxt;

    // Buffers are frozen outside IDLE so a run always sees one consistent operand set.
    assign wr_ok = wr_en && (state_q == S_IDLE) && (int'(wr_row) < N) && (int'(wr_col) < N);

    always_ff @(posedge CLK) begin
        if (rst) begin
            a_q <= '{default: '0};
            b_q <= '{default: '0};
        end else if (wr_ok) begin
            if (!wr_sel) a_q[wr_row][wr_col] <= wr_data;
            else         b_q[wr_row][wr_col] <= wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                state_d = S_STREAM;
                t_d     = '0;
            end
            S_STREAM: begin
                if (t_q == T_LAST) state_d = S_DONE;
                else               t_d     = t_q + TW'(1);
            end
            S_DONE: begin
                state_d = S_IDLE;
                t_d     = '0;
            end
            default: begin
                state_d = S_IDLE;
                t_d     = '0;
            end
        endcase
    end

    // Edge data is computed from the next step so it lands in the same cycle as pe_en.
    always_comb begin
        int d;
        d     = 0;
        a_nxt = '0;
        b_nxt = '0;
        if (state_d == S_STREAM) begin
            for (int i = 0; i < N; i++) begin
                d = int'(t_d) - i;
                if (d >= 0 && d < N) begin
                    a_nxt[i] = a_q[IW'(i)][d[IW-1:0]];
                    b_nxt[i] = b_q[d[IW-1:0]][IW'(i)];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pe_clr  <= 1'b0;
            pe_en   <= 1'b0;
            a_edge  <= '0;
            b_edge  <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            busy    <= (state_d != S_IDLE);
            done    <= (state_d == S_DONE);
            pe_clr  <= (state_d == S_CLEAR);
            pe_en   <= (state_d == S_STREAM);
            a_edge  <= a_nxt;
            b_edge  <= b_nxt;
        end
    end

endmodule

// File: tb/tb_sys_arr_feeder.sv
// Directed bench for sys_arr_feeder: skew table, protocol guards, mid-run reset,
// and an end-to-end check through a behavioural 4x4 MAC array.
module tb_sys_arr_feeder;
    localparam int N     = 4;
    localparam int STEPS = 3*N - 2;

    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        rst, wr_en, wr_sel, start;
    logic [1:0]  wr_row, wr_col;
    logic [7:0]  wr_data;
    logic        busy, done, pe_clr, pe_en;
    logic [31:0] a_edge, b_edge;

    logic        wr_en3, wr_sel3, start3;
    logic [1:0]  wr_row3, wr_col3;
    logic [7:0]  wr_data3;
    logic        busy3, done3, pe_clr3, pe_en3;
    logic [23:0] a_edge3, b_edge3;

    sys_arr_feeder #(.N(4)) dut (
        .CLK(CLK), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
        .wr_col(wr_col), .wr_data(wr_data), .start(start), .busy(busy), .done(done),
        .pe_clr(pe_clr), .pe_en(pe_en), .a_edge(a_edge), .b_edge(b_edge));

    sys_arr_feeder #(.N(3)) dut3 (
        .CLK(CLK), .rst(rst), .wr_en(wr_en3), .wr_sel(wr_sel3), .wr_row(wr_row3),
        .wr_col(wr_col3), .wr_data(wr_data3), .start(start3), .busy(busy3), .done(done3),
        .pe_clr(pe_clr3), .pe_en(pe_en3), .a_edge(a_edge3), .b_edge(b_edge3));

    int checks = 0;
    int errors = 0;

    logic [7:0]  ma [N][N];
    logic [7:0]  mb [N][N];
    logic [31:0] exp_a [STEPS];
    logic [31:0] exp_b [STEPS];

    typedef struct {
        int          t;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;
    vec_t skew [STEPS];

    // Behavioural output-stationary MAC array driven by the feeder.
    logic [7:0]  pa [N][N];
    logic [7:0]  pb [N][N];
    int unsigned pc [N][N];

    always @(posedge CLK) begin
        logic [7:0] ai, bi;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j == 0) ai = a_edge[8*i +: 8];
                else        ai = pa[i][j-1];
                if (i == 0) bi = b_edge[8*j +: 8];
                else        bi = pb[i-1][j];
                if (pe_clr) begin
                    pa[i][j] <= 8'h0;
                    pb[i][j] <= 8'h0;
                    pc[i][j] <= 0;
                end else if (pe_en) begin
                    pa[i][j] <= ai;
                    pb[i][j] <= bi;
                    pc[i][j] <= pc[i][j] + ai * bi;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, expv);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_ctl"}, {60'd0, busy, done, pe_clr, pe_en}, 64'd0);
        chk({nm, "_edge"}, {a_edge, b_edge}, 64'd0);
    endtask

    task automatic clr_model();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = 8'h0;
                mb[r][c] = 8'h0;
            end
    endtask

    task automatic fill_exp();
        for (int t = 0; t < STEPS; t++) begin
            exp_a[t] = '0;
            exp_b[t] = '0;
            for (int i = 0; i < N; i++) begin
                int d;
                d = t - i;
                if (d >= 0 && d < N) begin
                    exp_a[t][8*i +: 8] = ma[i][d];
                    exp_b[t][8*i +: 8] = mb[d][i];
                end
            end
        end
    endtask

    task automatic wr(input logic sel, input int row, input int col, input logic [7:0] data);
        @(negedge CLK);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_row  = row[1:0];
        wr_col  = col[1:0];
        wr_data = data;
        @(negedge CLK);
        wr_en = 1'b0;
        if (!sel) ma[row][col] = data;
        else      mb[row][col] = data;
    endtask

    // One run: inj_t injects start + A[0][0] write mid-stream, rst_t resets mid-stream,
    // ws writes A[1][0]=0x55 in the same cycle as start.
    task automatic run(input int inj_t, input int rst_t, input logic ws);
        @(negedge CLK);
        start = 1'b1;
        if (ws) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd1; wr_col = 2'd0; wr_data = 8'h55;
        end
        @(negedge CLK);
        start = 1'b0;
        wr_en = 1'b0;
        chk("clr_ctl", {60'd0, busy, done, pe_clr, pe_en}, 64'b1010);
        for (int t = 0; t < STEPS; t++) begin
            @(negedge CLK);
            start = 1'b0;
            wr_en = 1'b0;
            chk($sformatf("step%0d_ctl", t), {60'd0, busy, done, pe_clr, pe_en}, 64'b1001);
            chk($sformatf("step%0d_a", t), {32'd0, a_edge}, {32'd0, exp_a[t]});
            chk($sformatf("step%0d_b", t), {32'd0, b_edge}, {32'd0, exp_b[t]});
            if (t == inj_t) begin
                start = 1'b1;
                wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'hFF;
            end
            if (t == rst_t) begin
                rst = 1'b1;
                @(negedge CLK);
                rst = 1'b0;
                chk_idle("rst_mid");
                for (int k = 0; k < 16; k++) begin
                    @(negedge CLK);
                    chk("rst_quiet", {61'd0, busy, done, pe_en}, 64'd0);
                end
                clr_model();
                return;
            end
        end
        @(negedge CLK);
        chk("done_ctl", {60'd0, busy, done, pe_clr, pe_en}, 64'b1100);
        chk("done_edge", {a_edge, b_edge}, 64'd0);
        @(negedge CLK);
        chk_idle("post_run");
    endtask

    initial begin
        skew[0] = '{0, 32'h00000001, 32'h00000080};
        skew[1] = '{1, 32'h00001102, 32'h00008190};
        skew[2] = '{2, 32'h00211203, 32'h008291A0};
        skew[3] = '{3, 32'h31221304, 32'h8392A1B0};
        skew[4] = '{4, 32'h32231400, 32'h93A2B100};
        skew[5] = '{5, 32'h33240000, 32'hA3B20000};
        skew[6] = '{6, 32'h34000000, 32'hB3000000};
        skew[7] = '{7, 32'h00000000, 32'h00000000};
        skew[8] = '{8, 32'h00000000, 32'h00000000};
        skew[9] = '{9, 32'h00000000, 32'h00000000};

        rst = 1'b1;
        wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0; start = 1'b0;
        wr_en3 = 1'b0; wr_sel3 = 1'b0; wr_row3 = '0; wr_col3 = '0; wr_data3 = '0; start3 = 1'b0;

        // Reset held two cycles with random traffic on the inputs.
        for (int k = 0; k < 2; k++) begin
            wr_en = 1'($urandom); wr_sel = 1'($urandom); wr_row = 2'($urandom);
            wr_col = 2'($urandom); wr_data = 8'($urandom); start = 1'($urandom);
            @(negedge CLK);
            chk_idle("reset");
        end
        rst = 1'b0; wr_en = 1'b0; start = 1'b0;
        @(negedge CLK);
        chk_idle("reset_idle");

        clr_model();
        fill_exp();
        run(-1, -1, 1'b0);

        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                wr(1'b0, r, c, 8'(16*r + c + 1));
                wr(1'b1, r, c, 8'(8'h80 + 16*r + c));
            end
        for (int k = 0; k < STEPS; k++) begin
            exp_a[skew[k].t] = skew[k].a;
            exp_b[skew[k].t] = skew[k].b;
        end
        run(-1, -1, 1'b0);
        run(3, -1, 1'b0);
        run(-1, -1, 1'b0);

        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                wr(1'b0, r, c, (r == c) ? 8'd1 : 8'd0);
                wr(1'b1, r, c, 8'(4*r + c + 1));
            end
        fill_exp();
        run(-1, -1, 1'b0);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                chk($sformatf("mac_c%0d%0d", i, j), 64'(pc[i][j]), 64'(4*i + j + 1));

        fill_exp();
        run(-1, 5, 1'b0);
        fill_exp();
        run(-1, -1, 1'b0);

        ma[1][0] = 8'h55;
        fill_exp();
        run(-1, -1, 1'b1);

        // N=3: rows/cols of 3 are out of range and must not land anywhere.
        begin
            logic [3:0] sel_v;
            logic [1:0] row_v [5];
            logic [1:0] col_v [5];
            logic [7:0] dat_v [5];
            sel_v = 4'b0010;
            row_v = '{2'd0, 2'd0, 2'd3, 2'd3, 2'd1};
            col_v = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd3};
            dat_v = '{8'h11, 8'h22, 8'hEE, 8'hEE, 8'hEE};
            for (int k = 0; k < 5; k++) begin
                @(negedge CLK);
                wr_en3 = 1'b1;
                wr_sel3 = (k == 4) ? 1'b0 : (k == 3) ? 1'b1 : sel_v[k];
                wr_row3 = row_v[k]; wr_col3 = col_v[k]; wr_data3 = dat_v[k];
            end
            @(negedge CLK);
            wr_en3 = 1'b0;
            start3 = 1'b1;
            @(negedge CLK);
            start3 = 1'b0;
            chk("n3_clr", {60'd0, busy3, done3, pe_clr3, pe_en3}, 64'b1010);
            for (int t = 0; t < 7; t++) begin
                @(negedge CLK);
                chk($sformatf("n3_step%0d_ctl", t), {60'd0, busy3, done3, pe_clr3, pe_en3}, 64'b1001);
                chk($sformatf("n3_step%0d_a", t), {40'd0, a_edge3}, (t == 0) ? 64'h11 : 64'h0);
                chk($sformatf("n3_step%0d_b", t), {40'd0, b_edge3}, (t == 0) ? 64'h22 : 64'h0);
            end
            @(negedge CLK);
            chk("n3_done", {60'd0, busy3, done3, pe_clr3, pe_en3}, 64'b1100);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
